ram_dma_engine: RTL and testbench

Sequential initiator for the 4K×16 RAM array. It drives the RAM's data, write, read, enable and address inputs, and samples the RAM's data output. It performs FILL (write a constant to a run of words) and COPY (word-by-word forward copy between two regions) on a single START pulse, then reports completion. It sits between the processor control unit and the RAM, so bulk memory initialisation and moves need no per-word instruction sequencing.

---
 rtl/ram_dma_engine.sv | 122 ++++++++++++
 tb/tb_ram_dma_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma_engine.sv
// Sequential FILL/COPY initiator for a single-port word RAM.
// One access per cycle; COPY alternates read and write of each word.
module ram_dma_engine #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   input  logic          OP,
   input  logic [AW-1:0] SRC,
   input  logic [AW-1:0] DST,
   input  logic [AW-1:0] LEN,
   input  logic [DW-1:0] FILL_VAL,
   input  logic          ABORT,
   output logic          BUSY,
   output logic          DONE,
   output logic          MEM_E,
   output logic          MEM_W,
   output logic          MEM_R,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_D,
   input  logic [DW-1:0] MEM_Q
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t        state, nxt;
   logic          op_q;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;
   logic [AW-1:0] idx;
   logic [AW-1:0] rem;
   logic [DW-1:0] fill_q;
   logic [DW-1:0] hold;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         op_q   <= 1'b0;
         src_q  <= '0;
         dst_q  <= '0;
         idx    <= '0;
         rem    <= '0;
         fill_q <= '0;
         hold   <= '0;
      end else begin
         state <= nxt;
         case (state)
            S_IDLE: begin
               if (START) begin
                  op_q   <= OP;
                  src_q  <= SRC;
                  dst_q  <= DST;
                  rem    <= LEN;
                  fill_q <= FILL_VAL;
                  idx    <= '0;
               end
            end
            S_RD: hold <= MEM_Q;
            S_WR: begin
               idx <= idx + AW'(1);
               rem <= rem - AW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decode purely from registered state, so they hold steady for the whole access cycle.
   always_comb begin
      nxt      = state;
      BUSY     = 1'b0;
      DONE     = 1'b0;
      MEM_E    = 1'b0;
      MEM_W    = 1'b0;
      MEM_R    = 1'b0;
      MEM_ADDR = '0;
      MEM_D    = '0;
      case (state)
         S_IDLE: begin
            if (START) begin
               if (LEN == '0)
                  nxt = S_DONE;
               else if (OP)
                  nxt = S_RD;
               else
                  nxt = S_WR;
            end
         end
         S_RD: begin
            BUSY     = 1'b1;
            MEM_E    = 1'b1;
            MEM_R    = 1'b1;
            MEM_ADDR = src_q + idx;
            nxt      = ABORT ? S_DONE : S_WR;
         end
         S_WR: begin
            BUSY     = 1'b1;
            MEM_E    = 1'b1;
            MEM_W    = 1'b1;
            MEM_ADDR = dst_q + idx;
            MEM_D    = op_q ? hold : fill_q;
            if (ABORT || rem == AW'(1))
               nxt = S_DONE;
            else
               nxt = op_q ? S_RD : S_WR;
         end
         S_DONE: begin
            DONE = 1'b1;
            nxt  = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine with a behavioural 4Kx16 RAM attached.
// Transfers come from a vector table; reset-during-fill is a hand-written sequence.
module tb_ram_dma_engine;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        START, OP, ABORT;
   logic [11:0] SRC, DST, LEN;
   logic [15:0] FILL_VAL;
   logic        BUSY, DONE, MEM_E, MEM_W, MEM_R;
   logic [11:0] MEM_ADDR;
   logic [15:0] MEM_D, MEM_Q;

   logic [15:0] mem     [4096];
   logic [15:0] ref_mem [4096];

   int nchk = 0;
   int nerr = 0;
   int rd_cnt = 0, wr_cnt = 0, en_cnt = 0;

   ram_dma_engine #(.AW(12), .DW(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .SRC(SRC), .DST(DST),
      .LEN(LEN), .FILL_VAL(FILL_VAL), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
      .MEM_E(MEM_E), .MEM_W(MEM_W), .MEM_R(MEM_R), .MEM_ADDR(MEM_ADDR),
      .MEM_D(MEM_D), .MEM_Q(MEM_Q)
   );

   always #5 CLK = ~CLK;

   assign MEM_Q = mem[MEM_ADDR];

   always @(posedge CLK) begin
      if (MEM_E && MEM_W) mem[MEM_ADDR] <= MEM_D;
      if (MEM_E && MEM_R) rd_cnt <= rd_cnt + 1;
      if (MEM_E && MEM_W) wr_cnt <= wr_cnt + 1;
      if (MEM_E)          en_cnt <= en_cnt + 1;
   end

   typedef struct {
      string       name;
      bit          op;
      logic [11:0] src, dst, len;
      logic [15:0] fill;
      int          abort_wr;  // abort in this WR cycle (1-based), 0 = none
      bit          stray;     // pulse START again while busy
      int          exp_edge;  // DONE high in the cycle after this edge
      int          exp_rd, exp_wr;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_xfer(input int t);
      vec_t        v;
      int          rd0, wr0, en0, cyc, rseen, wseen, seq_err, ad_err, nwords, nd;
      bit          seen;
      logic [15:0] expd [$];
      logic [11:0] a;
      v = tbl[t];
      nwords = (v.abort_wr != 0) ? v.abort_wr : int'(v.len);
      for (int k = 0; k < nwords; k++) begin
         a = v.dst + 12'(k);
         expd.push_back(v.op ? ref_mem[v.src + 12'(k)] : v.fill);
         ref_mem[a] = expd[k];
      end
      rd0 = rd_cnt; wr0 = wr_cnt; en0 = en_cnt;
      cyc = 0; rseen = 0; wseen = 0; seq_err = 0; ad_err = 0; seen = 0;
      @(negedge CLK);
      START = 1'b1; OP = v.op; SRC = v.src; DST = v.dst; LEN = v.len; FILL_VAL = v.fill;
      @(negedge CLK);
      START = 1'b0; OP = ~v.op; SRC = 12'hABC; DST = 12'h777; LEN = 12'd5; FILL_VAL = 16'hDEAD;
      while (!seen && cyc < 200) begin
         if (DONE) seen = 1'b1;
         else begin
            ABORT = 1'b0;
            START = 1'b0;
            if (v.stray && cyc == 1) START = 1'b1;
            if (MEM_R) begin
               if (MEM_W || !v.op || rseen != wseen) seq_err++;
               if (MEM_ADDR !== v.src + 12'(rseen)) ad_err++;
               rseen++;
            end else if (MEM_W) begin
               if (v.op && rseen != wseen + 1) seq_err++;
               if (MEM_ADDR !== v.dst + 12'(wseen)) ad_err++;
               if (wseen >= nwords || MEM_D !== expd[wseen]) ad_err++;
               wseen++;
               if (v.abort_wr != 0 && wseen == v.abort_wr) ABORT = 1'b1;
            end
            if (BUSY !== (MEM_R | MEM_W) || MEM_E !== (MEM_R | MEM_W)) seq_err++;
            @(negedge CLK);
            cyc++;
         end
      end
      ABORT = 1'b0;
      START = 1'b0;
      chk({v.name, "_done_seen"}, 32'(seen), 32'd1);
      chk({v.name, "_latency"}, 32'(cyc), 32'(v.exp_edge));
      chk({v.name, "_done_outs"}, {BUSY, MEM_E, MEM_W, MEM_R}, 4'b0000);
      @(negedge CLK);
      chk({v.name, "_idle"}, {DONE, BUSY, MEM_E, MEM_ADDR, MEM_D}, '0);
      @(negedge CLK);
      chk({v.name, "_stays_idle"}, {DONE, BUSY, MEM_E}, 3'b000);
      chk({v.name, "_reads"}, 32'(rd_cnt - rd0), 32'(v.exp_rd));
      chk({v.name, "_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
      chk({v.name, "_enables"}, 32'(en_cnt - en0), 32'(v.exp_rd + v.exp_wr));
      chk({v.name, "_sequence"}, 32'(seq_err), 32'd0);
      chk({v.name, "_addr_data"}, 32'(ad_err), 32'd0);
      nd = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
      chk({v.name, "_mem_diffs"}, 32'(nd), 32'd0);
   endtask

   initial begin
      int nd;
      RST_N = 1'b0; START = 1'b0; OP = 1'b0; ABORT = 1'b0;
      SRC = '0; DST = '0; LEN = '0; FILL_VAL = '0;
      for (int i = 0; i < 4096; i++) begin
         mem[i] <= 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      for (int k = 0; k < 8; k++) begin
         mem[12'h100 + k] <= 16'(k);
         ref_mem[12'h100 + k] = 16'(k);
      end
      for (int k = 0; k < 4; k++) begin
         mem[12'h010 + k] <= 16'(k + 1);
         ref_mem[12'h010 + k] = 16'(k + 1);
      end
      for (int k = 0; k < 10; k++) begin
         mem[12'h400 + k] <= 16'h00A0 + 16'(k);
         ref_mem[12'h400 + k] = 16'h00A0 + 16'(k);
         mem[12'h500 + k] <= 16'hEEEE;
         ref_mem[12'h500 + k] = 16'hEEEE;
      end
      mem[12'h01F] <= 16'h1F1F; ref_mem[12'h01F] = 16'h1F1F;
      mem[12'h024] <= 16'h2424; ref_mem[12'h024] = 16'h2424;

      //            name           op  src     dst     len    fill      ab st edge rd wr
      tbl[0] = '{"fill4",        0, 12'h000, 12'h020, 12'd4,  16'h00AB, 0, 0, 4,  0, 4};
      tbl[1] = '{"copy8",        1, 12'h100, 12'h200, 12'd8,  16'hFFFF, 0, 0, 16, 8, 8};
      tbl[2] = '{"fill_wrap",    0, 12'h000, 12'hFFE, 12'd4,  16'h5555, 0, 0, 4,  0, 4};
      tbl[3] = '{"len0_fill",    0, 12'h000, 12'h600, 12'd0,  16'h1234, 0, 0, 0,  0, 0};
      tbl[4] = '{"copy_overlap", 1, 12'h010, 12'h011, 12'd3,  16'h0000, 0, 0, 6,  3, 3};
      tbl[5] = '{"copy_abort",   1, 12'h400, 12'h500, 12'd10, 16'h0000, 3, 0, 6,  3, 3};
      tbl[6] = '{"len0_copy",    1, 12'h100, 12'h650, 12'd0,  16'h0000, 0, 0, 0,  0, 0};
      tbl[7] = '{"after_reset",  0, 12'h000, 12'h310, 12'd2,  16'h4242, 0, 1, 2,  0, 2};

      #1;
      chk("reset_outs", {BUSY, DONE, MEM_E, MEM_W, MEM_R, MEM_ADDR, MEM_D}, '0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("idle_outs", {BUSY, DONE, MEM_E, MEM_W, MEM_R, MEM_ADDR, MEM_D}, '0);

      for (int t = 0; t < 7; t++) run_xfer(t);

      chk("wrap_fff", 32'(mem[12'hFFF]), 32'h5555);
      chk("wrap_001", 32'(mem[12'h001]), 32'h5555);
      chk("overlap_013", 32'(mem[12'h013]), 32'h0001);
      chk("abort_4th", 32'(mem[12'h503]), 32'hEEEE);
      chk("fill_edge_024", 32'(mem[12'h024]), 32'h2424);

      // reset during an 8-word fill, after its third write has committed
      for (int k = 0; k < 3; k++) ref_mem[12'h300 + k] = 16'h7777;
      @(negedge CLK);
      START = 1'b1; OP = 1'b0; DST = 12'h300; LEN = 12'd8; FILL_VAL = 16'h7777;
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_mid_busy", {BUSY, MEM_W, MEM_ADDR}, {2'b11, 12'h303});
      RST_N = 1'b0;
      #1;
      chk("rst_async_outs", {BUSY, DONE, MEM_E, MEM_W, MEM_R, MEM_ADDR, MEM_D}, '0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("rst_no_resume", {BUSY, DONE, MEM_E}, 3'b000);
      end
      nd = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
      chk("rst_mem_diffs", 32'(nd), 32'd0);

      run_xfer(7);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
